// File: rtl/reaction_pkg.sv
// Shared types and constants for the multi-player reaction timer.
package reaction_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PREP   = 3'd1,
    S_ARMED  = 3'd2,
    S_RESULT = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as a bit mask over [15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [3:0]  BCD_NINE  = 4'd9;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD up-counter that saturates at all 9s; digit 0 in [3:0].
module bcd_counter
  import reaction_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                inc,
  output logic [4*DIGITS-1:0] value,
  output logic                all_nine
);

  logic [4*DIGITS-1:0] value_nxt;
  logic                carry;

  always_comb begin
    all_nine = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (value[4*i +: 4] != BCD_NINE) all_nine = 1'b0;
    end
  end

  always_comb begin
    value_nxt = value;
    carry     = inc & ~all_nine;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (value[4*i +: 4] == BCD_NINE) begin
          value_nxt[4*i +: 4] = 4'd0;
        end else begin
          value_nxt[4*i +: 4] = value[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    value <= '0;
    else if (clr) value <= '0;
    else          value <= value_nxt;
  end

endmodule

// File: rtl/reaction_timer_multi.sv
// Multi-player reaction timer core: prep delay, stimulus, BCD ms timing, arbitration.
// Best-time tracking is built only when REACTION_BEST_TIME_EN is defined.
module reaction_timer_multi
  import reaction_pkg::*;
#(
  parameter  int unsigned CLK_PER_MS      = 100000,
  parameter  int unsigned NUM_PLAYERS     = 2,
  parameter  int unsigned DIGITS          = 4,
  parameter  int unsigned PREP_MIN_MS     = 1000,
  parameter  int unsigned PREP_RANGE_MASK = 2047,
  localparam int unsigned PW              = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_btn,
  input  logic [NUM_PLAYERS-1:0] player_btn,
  output logic                   stim_led,
  output logic [4*DIGITS-1:0]    time_bcd,
  output logic [PW-1:0]          winner,
  output logic                   winner_valid,
  output logic                   false_start,
  output logic                   timeout,
  output logic [4*DIGITS-1:0]    best_bcd,
  output logic [2:0]             state_out
);

  localparam int unsigned TW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

  logic [TW-1:0]          tick_cnt;
  logic                   tick;
  logic [15:0]            lfsr;
  logic                   start_prev;
  logic [NUM_PLAYERS-1:0] player_prev;
  logic                   start_edge;
  logic [NUM_PLAYERS-1:0] player_edge;
  logic                   any_press;
  logic [PW-1:0]          press_idx;
  state_t                 state, state_nxt;
  logic [31:0]            prep_cnt;
  logic [31:0]            prep_raw;
  logic [31:0]            prep_load;
  logic                   enter_prep, go_fault, go_win, go_timeout, time_inc;
  logic                   time_sat;

  function automatic logic [PW-1:0] lowest_idx(input logic [NUM_PLAYERS-1:0] v);
    lowest_idx = '0;
    for (int unsigned i = NUM_PLAYERS; i > 0; i--) begin
      if (v[i-1]) lowest_idx = PW'(i-1);
    end
  endfunction

  assign tick = (tick_cnt == TW'(CLK_PER_MS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt    <= '0;
      lfsr        <= LFSR_SEED;
      start_prev  <= 1'b0;
      player_prev <= '0;
    end else begin
      tick_cnt    <= tick ? '0 : tick_cnt + TW'(1);
      lfsr        <= lfsr_next(lfsr);
      start_prev  <= start_btn;
      player_prev <= player_btn;
    end
  end

  assign start_edge  = start_btn & ~start_prev;
  assign player_edge = player_btn & ~player_prev;
  assign any_press   = |player_edge;
  assign press_idx   = lowest_idx(player_edge);

  // A zero-length delay is stretched to one tick so ARMED is always reachable
  assign prep_raw  = PREP_MIN_MS + (32'(lfsr) & PREP_RANGE_MASK);
  assign prep_load = (prep_raw == 32'd0) ? 32'd1 : prep_raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    enter_prep = 1'b0;
    go_fault   = 1'b0;
    go_win     = 1'b0;
    go_timeout = 1'b0;
    time_inc   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_edge) begin
          state_nxt  = S_PREP;
          enter_prep = 1'b1;
        end
      end
      S_PREP: begin
        if (any_press) begin
          state_nxt = S_FAULT;
          go_fault  = 1'b1;
        end else if (tick && prep_cnt <= 32'd1) begin
          state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        if (any_press) begin
          state_nxt = S_RESULT;
          go_win    = 1'b1;
        end else if (tick) begin
          if (time_sat) begin
            state_nxt  = S_RESULT;
            go_timeout = 1'b1;
          end else begin
            time_inc = 1'b1;
          end
        end
      end
      S_RESULT, S_FAULT: begin
        if (start_edge) begin
          state_nxt  = S_PREP;
          enter_prep = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stim_led     <= 1'b0;
      winner       <= '0;
      winner_valid <= 1'b0;
      false_start  <= 1'b0;
      timeout      <= 1'b0;
      prep_cnt     <= '0;
    end else begin
      stim_led <= (state_nxt == S_ARMED);
      if (enter_prep) begin
        winner       <= '0;
        winner_valid <= 1'b0;
        false_start  <= 1'b0;
        timeout      <= 1'b0;
        prep_cnt     <= prep_load;
      end else if (state == S_PREP && tick) begin
        prep_cnt <= prep_cnt - 32'd1;
      end
      if (go_fault) begin
        false_start  <= 1'b1;
        winner       <= press_idx;
        winner_valid <= 1'b0;
      end
      if (go_win) begin
        winner       <= press_idx;
        winner_valid <= 1'b1;
      end
      if (go_timeout) begin
        timeout      <= 1'b1;
        winner_valid <= 1'b0;
      end
    end
  end

  bcd_counter #(
    .DIGITS (DIGITS)
  ) u_time (
    .clk      (clk),
    .reset    (reset),
    .clr      (enter_prep),
    .inc      (time_inc),
    .value    (time_bcd),
    .all_nine (time_sat)
  );

`ifdef REACTION_BEST_TIME_EN
  // Packed BCD compares correctly as binary since every digit is 0..9
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             best_bcd <= {DIGITS{BCD_NINE}};
    else if (go_win && time_bcd < best_bcd) best_bcd <= time_bcd;
  end
`else
  assign best_bcd = {DIGITS{BCD_NINE}};
`endif

  assign state_out = state;

endmodule
